hazard_ctrl: RTL and testbench

Central pipeline hazard controller. It is the producer side of every pipeline register's stall/flush inputs. It turns D-Cache busy, EX-stage taken branches and ID-stage load-use hazards into per-stage stall/flush controls and a PC redirect. It also holds any branch redirect that arrives while the pipe is frozen, and issues it exactly once after the freeze ends.

---
 rtl/hazard_ctrl_pkg.sv | 38 +++
 rtl/hazard_ctrl_event_counter.sv | 32 +++
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared constants and types for the pipeline hazard controller
package hazard_ctrl_pkg;

  // Default datapath / PC width.
  localparam int unsigned HC_WORD = 32;

  // Controller state encoding.
  localparam int unsigned HC_ST_W     = 2;
  localparam logic [1:0]  ST_RUN      = 2'd0;
  localparam logic [1:0]  ST_BUBBLE   = 2'd1;
  localparam logic [1:0]  ST_MEM_WAIT = 2'd2;

  // Per-stage pipeline register controls, in output-port order.
  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_mem_wb;
  } hc_ctrl_t;

  // D-Cache freeze: hold everything up to EX/MEM and drop a bubble into MEM/WB.
  localparam hc_ctrl_t CTRL_NONE   = '0;
  localparam hc_ctrl_t CTRL_BUSY   = '{stall_pc: 1'b1, stall_if_id: 1'b1, stall_id_ex: 1'b1,
                                       stall_ex_mem: 1'b1, flush_if_id: 1'b0, flush_id_ex: 1'b0,
                                       flush_mem_wb: 1'b1};
  // Taken branch: squash the two younger instructions, nothing is held.
  localparam hc_ctrl_t CTRL_REDIR  = '{stall_pc: 1'b0, stall_if_id: 1'b0, stall_id_ex: 1'b0,
                                       stall_ex_mem: 1'b0, flush_if_id: 1'b1, flush_id_ex: 1'b1,
                                       flush_mem_wb: 1'b0};
  // Load-use bubble: hold fetch/decode, inject a NOP into ID/EX.
  localparam hc_ctrl_t CTRL_BUBBLE = '{stall_pc: 1'b1, stall_if_id: 1'b1, stall_id_ex: 1'b0,
                                       stall_ex_mem: 1'b0, flush_if_id: 1'b0, flush_id_ex: 1'b1,
                                       flush_mem_wb: 1'b0};

endpackage

// File: rtl/hazard_ctrl_event_counter.sv
// rtl/hazard_ctrl_event_counter.sv - saturating debug event counter with enable
module hc_event_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Count enabled cycles, sticking at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (en && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/redirect controller
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned WORD             = HC_WORD,
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             HC_dcache_busy,
  input  logic             HC_ex_branch_taken,
  input  logic [WORD-1:0]  HC_ex_branch_target,
  input  logic             HC_id_load_use,
  output logic             HC_stall_PC,
  output logic             HC_stall_IF_ID,
  output logic             HC_stall_ID_EX,
  output logic             HC_stall_EX_MEM,
  output logic             HC_flush_IF_ID,
  output logic             HC_flush_ID_EX,
  output logic             HC_flush_MEM_WB,
  output logic             HC_redirect_valid,
  output logic [WORD-1:0]  HC_redirect_PC,
  output logic [CNT_W-1:0] HC_stall_cycles,
  output logic [CNT_W-1:0] HC_flush_count
);

  // Bubbles still owed after the first one that a fresh hazard inserts.
  localparam logic [2:0] FIRST_REMAIN = 3'(LOAD_USE_BUBBLES - 1);

  logic [HC_ST_W-1:0] state_q, state_d;
  logic               pend_valid_q, pend_valid_d;
  logic [WORD-1:0]    pend_pc_q, pend_pc_d;
  logic [2:0]         bub_cnt_q, bub_cnt_d;
  logic               saved_bubble_q, saved_bubble_d;

  hc_ctrl_t           ctrl;
  logic               redirect;
  logic [WORD-1:0]    redirect_pc;
  logic               bubble_hit;

  // Priority decode busy > redirect > load-use, plus next-state for all registers.
  always_comb begin
    state_d        = state_q;
    pend_valid_d   = pend_valid_q;
    pend_pc_d      = pend_pc_q;
    bub_cnt_d      = bub_cnt_q;
    saved_bubble_d = saved_bubble_q;
    ctrl           = CTRL_NONE;
    redirect       = 1'b0;
    redirect_pc    = '0;
    bubble_hit     = ((state_q == ST_RUN) && HC_id_load_use) ||
                     (state_q == ST_BUBBLE) ||
                     ((state_q == ST_MEM_WAIT) && saved_bubble_q);

    if (HC_dcache_busy) begin
      // Freeze: remember an interrupted bubble sequence and latch the first
      // branch target, since ID/EX would ignore a flush while stalled.
      ctrl           = CTRL_BUSY;
      state_d        = ST_MEM_WAIT;
      saved_bubble_d = saved_bubble_q || (state_q == ST_BUBBLE);
      if (HC_ex_branch_taken && !pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = HC_ex_branch_target;
      end
    end else if (pend_valid_q || HC_ex_branch_taken) begin
      // Redirect squashes the dependent instruction, so owed bubbles are dropped.
      ctrl           = CTRL_REDIR;
      redirect       = 1'b1;
      redirect_pc    = pend_valid_q ? pend_pc_q : HC_ex_branch_target;
      pend_valid_d   = 1'b0;
      bub_cnt_d      = '0;
      saved_bubble_d = 1'b0;
      state_d        = ST_RUN;
    end else if (bubble_hit) begin
      ctrl           = CTRL_BUBBLE;
      saved_bubble_d = 1'b0;
      if (state_q == ST_RUN) begin
        bub_cnt_d = FIRST_REMAIN;
        state_d   = (FIRST_REMAIN == 3'd0) ? ST_RUN : ST_BUBBLE;
      end else begin
        bub_cnt_d = bub_cnt_q - 3'd1;
        state_d   = (bub_cnt_q == 3'd1) ? ST_RUN : ST_BUBBLE;
      end
    end else begin
      state_d = ST_RUN;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      pend_valid_q   <= 1'b0;
      pend_pc_q      <= '0;
      bub_cnt_q      <= '0;
      saved_bubble_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_valid_q   <= pend_valid_d;
      pend_pc_q      <= pend_pc_d;
      bub_cnt_q      <= bub_cnt_d;
      saved_bubble_q <= saved_bubble_d;
    end
  end

  // Outputs are combinational and forced quiet while reset is asserted.
  always_comb begin
    HC_stall_PC       = !rst && ctrl.stall_pc;
    HC_stall_IF_ID    = !rst && ctrl.stall_if_id;
    HC_stall_ID_EX    = !rst && ctrl.stall_id_ex;
    HC_stall_EX_MEM   = !rst && ctrl.stall_ex_mem;
    HC_flush_IF_ID    = !rst && ctrl.flush_if_id;
    HC_flush_ID_EX    = !rst && ctrl.flush_id_ex;
    HC_flush_MEM_WB   = !rst && ctrl.flush_mem_wb;
    HC_redirect_valid = !rst && redirect;
    HC_redirect_PC    = rst ? '0 : redirect_pc;
  end

  hc_event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (HC_dcache_busy),
    .count (HC_stall_cycles)
  );

  hc_event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (redirect),
    .count (HC_flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int LUB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy, taken, lu;
  logic [31:0] target;
  logic        s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, f_memwb, rv;
  logic [31:0] rpc, stall_cycles, flush_count;
  logic [6:0]  ctrl_obs;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bubbles owed, one pending redirect, whether last cycle was frozen.
  logic        m_pend_v;
  logic [31:0] m_pend_pc;
  int          m_owed;
  logic        m_prev_busy;
  int          m_stalls;
  int          m_flushes;

  always #5 clk = ~clk;

  hazard_ctrl #(.WORD(32), .LOAD_USE_BUBBLES(LUB), .CNT_W(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .HC_dcache_busy      (busy),
    .HC_ex_branch_taken  (taken),
    .HC_ex_branch_target (target),
    .HC_id_load_use      (lu),
    .HC_stall_PC         (s_pc),
    .HC_stall_IF_ID      (s_ifid),
    .HC_stall_ID_EX      (s_idex),
    .HC_stall_EX_MEM     (s_exmem),
    .HC_flush_IF_ID      (f_ifid),
    .HC_flush_ID_EX      (f_idex),
    .HC_flush_MEM_WB     (f_memwb),
    .HC_redirect_valid   (rv),
    .HC_redirect_PC      (rpc),
    .HC_stall_cycles     (stall_cycles),
    .HC_flush_count      (flush_count)
  );

  assign ctrl_obs = {s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, f_memwb};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend_v    = 1'b0;
    m_pend_pc   = '0;
    m_owed      = 0;
    m_prev_busy = 1'b0;
    m_stalls    = 0;
    m_flushes   = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {57'd0, ctrl_obs}, 64'd0);
    check({tag, "_rv"}, {63'd0, rv}, 64'd0);
    check({tag, "_rpc"}, {32'd0, rpc}, 64'd0);
    check({tag, "_stall_cnt"}, {32'd0, stall_cycles}, 64'd0);
    check({tag, "_flush_cnt"}, {32'd0, flush_count}, 64'd0);
  endtask

  // One cycle starting at a negedge: apply inputs, compare with the model, advance on posedge.
  task automatic step(input logic b, input logic t, input logic [31:0] tg, input logic l);
    logic [6:0]  exp_ctrl;
    logic        exp_rv;
    logic [31:0] exp_pc;
    busy = b; taken = t; target = tg; lu = l;
    #2;
    exp_ctrl = 7'b0000000;
    exp_rv   = 1'b0;
    exp_pc   = '0;
    check("stall_cnt", {32'd0, stall_cycles}, 64'(m_stalls));
    check("flush_cnt", {32'd0, flush_count}, 64'(m_flushes));
    if (b) begin
      exp_ctrl = 7'b1111001;
    end else if (m_pend_v || t) begin
      exp_ctrl = 7'b0000110;
      exp_rv   = 1'b1;
      exp_pc   = m_pend_v ? m_pend_pc : tg;
    end else if (m_owed > 0 || (l && !m_prev_busy)) begin
      exp_ctrl = 7'b1100010;
    end
    check("ctrl", {57'd0, ctrl_obs}, {57'd0, exp_ctrl});
    check("redirect_valid", {63'd0, rv}, {63'd0, exp_rv});
    if (exp_rv) check("redirect_pc", {32'd0, rpc}, {32'd0, exp_pc});
    @(posedge clk);
    if (b) begin
      if (t && !m_pend_v) begin
        m_pend_v  = 1'b1;
        m_pend_pc = tg;
      end
      m_stalls++;
    end else if (m_pend_v || t) begin
      m_pend_v = 1'b0;
      m_owed   = 0;
      m_flushes++;
    end else if (m_owed > 0) begin
      m_owed--;
    end else if (l && !m_prev_busy) begin
      m_owed = LUB - 1;
    end
    m_prev_busy = b;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; busy = 1'b0; taken = 1'b0; lu = 1'b0; target = '0;
    model_reset();
    @(negedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Three freeze cycles.
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t1_stall_cycles", {32'd0, stall_cycles}, 64'd3);

    // Unfrozen taken branch redirects in the same cycle.
    step(1'b0, 1'b1, 32'h1C00_0040, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_flush_count", {32'd0, flush_count}, 64'd1);

    // Branch arriving during a freeze: first target held, issued once afterwards.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h1C00_0100, 1'b0);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check("t3_pc_held", {32'd0, rpc}, 64'd0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t3_flush_count", {32'd0, flush_count}, 64'd2);

    // Two-bubble load-use split by a two-cycle freeze.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // Load-use and branch together: redirect wins, no bubble afterwards.
    step(1'b0, 1'b1, 32'h1C00_0200, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // Asynchronous reset during a freeze with a redirect pending.
    step(1'b1, 1'b1, 32'h1C00_0300, 1'b0);
    busy = 1'b1; taken = 1'b1; target = 32'h1C00_0300;
    #1 rst = 1'b1;
    #1;
    check_all_zero("t6_async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t6_no_redirect", {32'd0, flush_count}, 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 15), $urandom,
           ($urandom_range(0, 99) < 25));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
